// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store port: MEM_* function codes, widths,
// FSM state encoding and small decode helpers.
package lsu_pkg;

    localparam int LSU_XLEN = 32;
    localparam int LSU_BE_W = LSU_XLEN / 8;
    localparam int LSU_FN_W = 3;

    localparam logic [LSU_FN_W-1:0] MEM_LB  = 3'd0;
    localparam logic [LSU_FN_W-1:0] MEM_LH  = 3'd1;
    localparam logic [LSU_FN_W-1:0] MEM_LW  = 3'd2;
    localparam logic [LSU_FN_W-1:0] MEM_LBU = 3'd3;
    localparam logic [LSU_FN_W-1:0] MEM_LHU = 3'd4;
    localparam logic [LSU_FN_W-1:0] MEM_SB  = 3'd5;
    localparam logic [LSU_FN_W-1:0] MEM_SH  = 3'd6;
    localparam logic [LSU_FN_W-1:0] MEM_SW  = 3'd7;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_ACC0 = 2'd1,
        LSU_ACC1 = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    function automatic lsu_size_e fn_size(input logic [LSU_FN_W-1:0] fn);
        lsu_size_e sz;
        case (fn)
            MEM_LB, MEM_LBU, MEM_SB: sz = SZ_B;
            MEM_LH, MEM_LHU, MEM_SH: sz = SZ_H;
            default:                 sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic fn_store(input logic [LSU_FN_W-1:0] fn);
        return (fn == MEM_SB) || (fn == MEM_SH) || (fn == MEM_SW);
    endfunction

    function automatic logic fn_signed(input logic [LSU_FN_W-1:0] fn);
        return (fn == MEM_LB) || (fn == MEM_LH);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: shifts store data/byte mask into a two-word
// window and extracts/extends load data from the same window.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [LSU_FN_W-1:0]   fn,
    input  logic [1:0]            offset,
    input  logic [LSU_XLEN-1:0]   wdata,
    input  logic [2*LSU_XLEN-1:0] rdata,
    output logic [2*LSU_XLEN-1:0] st_data,
    output logic [2*LSU_BE_W-1:0] st_mask,
    output logic [LSU_XLEN-1:0]   ld_data
);

    logic [4:0]            shamt;
    logic [2*LSU_BE_W-1:0] base_mask;
    logic [LSU_XLEN-1:0]   raw;
    logic                  sgn;

    assign shamt   = {offset, 3'b000};
    assign sgn     = fn_signed(fn);
    assign st_data = {{LSU_XLEN{1'b0}}, wdata} << shamt;
    assign st_mask = base_mask << offset;
    assign raw     = LSU_XLEN'(rdata >> shamt);

    always_comb begin
        base_mask = 8'b0000_1111;
        ld_data   = raw;
        case (fn_size(fn))
            SZ_B: begin
                base_mask = 8'b0000_0001;
                ld_data   = {{24{raw[7] & sgn}}, raw[7:0]};
            end
            SZ_H: begin
                base_mask = 8'b0000_0011;
                ld_data   = {{16{raw[15] & sgn}}, raw[15:0]};
            end
            default: begin
                base_mask = 8'b0000_1111;
                ld_data   = raw;
            end
        endcase
    end

endmodule

// File: rtl/lsu_port.sv
// Single-outstanding load/store port onto a word-wide memory with ack handshake.
// Define LSU_MISALIGN_EN to split misaligned accesses into two word accesses; otherwise they fail with resp_err.
module lsu_port
    import lsu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [LSU_FN_W-1:0] req_fn,
    input  logic [LSU_XLEN-1:0] req_addr,
    input  logic [LSU_XLEN-1:0] req_wdata,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [LSU_XLEN-1:0] resp_data,
    output logic                resp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [LSU_XLEN-1:0] mem_addr,
    output logic [LSU_BE_W-1:0] mem_be,
    output logic [LSU_XLEN-1:0] mem_wdata,
    input  logic [LSU_XLEN-1:0] mem_rdata,
    input  logic                mem_ack
);

    lsu_state_e state, state_nxt;

    logic [LSU_FN_W-1:0]   fn_q;
    logic [LSU_XLEN-1:0]   addr_q, wdata_q, rdata0_q;
    logic                  split_q;
    logic                  split_d, err_d, accept, done, is_st;
    logic [LSU_XLEN-1:0]   word_addr, ld_lo, ld_hi, ld_data;
    logic [2*LSU_XLEN-1:0] st_data;
    logic [2*LSU_BE_W-1:0] st_mask;

`ifdef LSU_MISALIGN_EN
    assign split_d = (fn_size(req_fn) == SZ_W) ? (req_addr[1:0] != 2'd0)
                   : ((fn_size(req_fn) == SZ_H) && (req_addr[1:0] == 2'd3));
    assign err_d   = 1'b0;
`else
    assign split_d = 1'b0;
    assign err_d   = ((fn_size(req_fn) == SZ_H) && req_addr[0])
                   || ((fn_size(req_fn) == SZ_W) && (req_addr[1:0] != 2'd0));
`endif

    // Ready is gated by reset so it reads 0 while reset is held, not just IDLE.
    assign req_ready  = reset && (state == LSU_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == LSU_RESP);
    assign is_st      = fn_store(fn_q);
    assign word_addr  = {addr_q[LSU_XLEN-1:2], 2'b00};
    assign done       = mem_ack && (((state == LSU_ACC0) && !split_q) || (state == LSU_ACC1));

    // Low word comes from the ACC0 capture once a second access is in flight.
    assign ld_lo = (state == LSU_ACC1) ? rdata0_q  : mem_rdata;
    assign ld_hi = (state == LSU_ACC1) ? mem_rdata : '0;

    lsu_align u_align (
        .fn      (fn_q),
        .offset  (addr_q[1:0]),
        .wdata   (wdata_q),
        .rdata   ({ld_hi, ld_lo}),
        .st_data (st_data),
        .st_mask (st_mask),
        .ld_data (ld_data)
    );

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (state)
            LSU_IDLE: if (accept) state_nxt = err_d ? LSU_RESP : LSU_ACC0;
            LSU_ACC0: begin
                mem_req   = 1'b1;
                mem_we    = is_st;
                mem_addr  = word_addr;
                mem_be    = st_mask[LSU_BE_W-1:0];
                mem_wdata = is_st ? st_data[LSU_XLEN-1:0] : '0;
                if (mem_ack) state_nxt = split_q ? LSU_ACC1 : LSU_RESP;
            end
            LSU_ACC1: begin
                mem_req   = 1'b1;
                mem_we    = is_st;
                mem_addr  = word_addr + LSU_XLEN'(4);
                mem_be    = st_mask[2*LSU_BE_W-1:LSU_BE_W];
                mem_wdata = is_st ? st_data[2*LSU_XLEN-1:LSU_XLEN] : '0;
                if (mem_ack) state_nxt = LSU_RESP;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LSU_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fn_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            split_q   <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            if (accept) begin
                fn_q    <= req_fn;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                split_q <= split_d;
                if (err_d) begin
                    resp_data <= '0;
                    resp_err  <= 1'b1;
                end
            end
            if ((state == LSU_ACC0) && mem_ack) rdata0_q <= mem_rdata;
            if (done) begin
                resp_data <= is_st ? '0 : ld_data;
                resp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_port.sv
// Directed, table-driven bench for lsu_port; split-access vectors apply when LSU_MISALIGN_EN is defined.
module tb_lsu_port;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_fn = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string            nm;
        logic [2:0]       fn;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        int               nacc;   // 0 = rejected as misaligned
        int               dly;
        logic [1:0][31:0] rdata;
        logic [1:0][31:0] eaddr;
        logic [1:0][3:0]  ebe;
        logic [1:0][31:0] ewdata;
        logic [31:0]      edata;
    } vec_t;

    vec_t vecs[$];

    lsu_port dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_fn(req_fn),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] fn, input logic [31:0] addr,
                                input logic [31:0] wdata, input int nacc, input int dly,
                                input logic [31:0] r0, input logic [31:0] r1,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [3:0] b0, input logic [3:0] b1,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] edata);
        vec_t v;
        v.nm = nm; v.fn = fn; v.addr = addr; v.wdata = wdata; v.nacc = nacc; v.dly = dly;
        v.rdata[0] = r0; v.rdata[1] = r1; v.eaddr[0] = a0; v.eaddr[1] = a1;
        v.ebe[0] = b0; v.ebe[1] = b1; v.ewdata[0] = w0; v.ewdata[1] = w1; v.edata = edata;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic st;
        st = (v.fn == MEM_SB) || (v.fn == MEM_SH) || (v.fn == MEM_SW);
        @(posedge clk); #1;
        check({v.nm, " ready_idle"}, req_ready, 1);
        req_valid = 1'b1; req_fn = v.fn; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        // Scramble the request bus: the registered copy must be used.
        req_valid = 1'b0; req_fn = ~v.fn; req_addr = ~v.addr; req_wdata = ~v.wdata;
        if (v.nacc == 0) begin
            check({v.nm, " err_mem_req"}, mem_req, 0);
            check({v.nm, " err_resp_valid"}, resp_valid, 1);
            check({v.nm, " err_resp_err"}, resp_err, 1);
            check({v.nm, " err_resp_data"}, resp_data, 0);
        end else begin
            for (int k = 0; k < v.nacc; k++) begin
                for (int d = 0; d <= v.dly; d++) begin
                    check({v.nm, " busy_ready"}, req_ready, 0);
                    check({v.nm, " mem_req"}, mem_req, 1);
                    check({v.nm, " mem_addr"}, mem_addr, v.eaddr[k]);
                    check({v.nm, " mem_be"}, {28'd0, mem_be}, {28'd0, v.ebe[k]});
                    check({v.nm, " mem_we"}, mem_we, st);
                    if (st) check({v.nm, " mem_wdata"}, mem_wdata, v.ewdata[k]);
                    check({v.nm, " early_resp"}, resp_valid, 0);
                    mem_ack   = (d == v.dly);
                    mem_rdata = (d == v.dly) ? v.rdata[k] : 32'h5A5A_0000 | d;
                    @(posedge clk); #1;
                    mem_ack = 1'b0; mem_rdata = 32'hC3C3_C3C3;
                end
            end
            check({v.nm, " resp_valid"}, resp_valid, 1);
            check({v.nm, " resp_err"}, resp_err, 0);
            check({v.nm, " resp_data"}, resp_data, v.edata);
            check({v.nm, " resp_mem_req"}, mem_req, 0);
        end
        @(posedge clk); #1;
        check({v.nm, " pulse_end"}, resp_valid, 0);
        check({v.nm, " data_held"}, resp_data, (v.nacc == 0) ? 32'd0 : v.edata);
        check({v.nm, " ready_again"}, req_ready, 1);
    endtask

    initial begin
        vecs.push_back(mk("lw_100",  MEM_LW,  32'h100, 32'h0, 1, 0, 32'h8899AABB, 0, 32'h100, 0, 4'hF, 0, 0, 0, 32'h8899AABB));
        vecs.push_back(mk("lb_103",  MEM_LB,  32'h103, 32'h0, 1, 0, 32'h80000000, 0, 32'h100, 0, 4'h8, 0, 0, 0, 32'hFFFFFF80));
        vecs.push_back(mk("lbu_103", MEM_LBU, 32'h103, 32'h0, 1, 0, 32'h80000000, 0, 32'h100, 0, 4'h8, 0, 0, 0, 32'h00000080));
        vecs.push_back(mk("lh_102",  MEM_LH,  32'h102, 32'h0, 1, 2, 32'h80011234, 0, 32'h100, 0, 4'hC, 0, 0, 0, 32'hFFFF8001));
        vecs.push_back(mk("lhu_102", MEM_LHU, 32'h102, 32'h0, 1, 1, 32'h80011234, 0, 32'h100, 0, 4'hC, 0, 0, 0, 32'h00008001));
        vecs.push_back(mk("lh_100",  MEM_LH,  32'h100, 32'h0, 1, 0, 32'h12347FFF, 0, 32'h100, 0, 4'h3, 0, 0, 0, 32'h00007FFF));
        vecs.push_back(mk("lb_201",  MEM_LB,  32'h201, 32'h0, 1, 0, 32'h00007F00, 0, 32'h200, 0, 4'h2, 0, 0, 0, 32'h0000007F));
        vecs.push_back(mk("sb_201",  MEM_SB,  32'h201, 32'h11223344, 1, 0, 32'hFFFFFFFF, 0, 32'h200, 0, 4'h2, 0, 32'h22334400, 0, 32'h0));
        vecs.push_back(mk("sb_203",  MEM_SB,  32'h203, 32'h11223344, 1, 0, 32'hFFFFFFFF, 0, 32'h200, 0, 4'h8, 0, 32'h44000000, 0, 32'h0));
        vecs.push_back(mk("sh_302",  MEM_SH,  32'h302, 32'hAABBCCDD, 1, 1, 32'hFFFFFFFF, 0, 32'h300, 0, 4'hC, 0, 32'hCCDD0000, 0, 32'h0));
        vecs.push_back(mk("sw_top",  MEM_SW,  32'hFFFFFFFC, 32'hDEADBEEF, 1, 0, 32'h0, 0, 32'hFFFFFFFC, 0, 4'hF, 0, 32'hDEADBEEF, 0, 32'h0));
`ifdef LSU_MISALIGN_EN
        vecs.push_back(mk("lh_101",  MEM_LH,  32'h101, 32'h0, 1, 0, 32'h00ABCD00, 0, 32'h100, 0, 4'h6, 0, 0, 0, 32'hFFFFABCD));
        vecs.push_back(mk("sw_102",  MEM_SW,  32'h102, 32'h11223344, 2, 0, 0, 0, 32'h100, 32'h104, 4'hC, 4'h3, 32'h33440000, 32'h00001122, 32'h0));
        vecs.push_back(mk("lh_103",  MEM_LH,  32'h103, 32'h0, 2, 3, 32'hAB000000, 32'h000000CD, 32'h100, 32'h104, 4'h8, 4'h1, 0, 0, 32'hFFFFCDAB));
        vecs.push_back(mk("lw_wrap", MEM_LW,  32'hFFFFFFFE, 32'h0, 2, 1, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFC, 32'h0, 4'hC, 4'h3, 0, 0, 32'hDEF01234));
`else
        vecs.push_back(mk("lw_101_err",  MEM_LW,  32'h101, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lh_103_err",  MEM_LH,  32'h103, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lhu_101_err", MEM_LHU, 32'h101, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sw_102_err",  MEM_SW,  32'h102, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_data", resp_data, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_req_ready", req_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // mem_ack while idle must not start or complete anything
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("idle_ack_resp_valid", resp_valid, 0);
        check("idle_ack_mem_req", mem_req, 0);
        check("idle_ack_ready", req_ready, 1);

        // Reset while waiting on the last access of a request
        @(posedge clk); #1;
        req_valid = 1'b1; req_fn = MEM_LW;
`ifdef LSU_MISALIGN_EN
        req_addr = 32'h202;
`else
        req_addr = 32'h200;
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("rst_mid_addr", mem_addr, 32'h204);
`else
        check("rst_mid_addr", mem_addr, 32'h200);
`endif
        @(posedge clk); #1;
        check("rst_mid_wait_req", mem_req, 1);
        reset = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_ready", req_ready, 0);
        check("rst_mid_resp_valid", resp_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_rel_ready", req_ready, 1);
        @(posedge clk); #1;
        check("rst_mid_no_resp", resp_valid, 0);
        check("rst_mid_no_req", mem_req, 0);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have req_valid  input  1  pipeline memory request present.
REQ-004 SHALL have req_fn  input  3  MEM_* code from define.vh (LB/LBU/LH/LHU/LW/SB/SH/SW).
REQ-005 SHALL have req_addr  input  32  byte address; req_wdata  input  32  store data.
REQ-006 SHALL have req_ready  output  1  request accepted this cycle when req_valid & req_ready.
REQ-007 SHALL have resp_valid  output  1  one-cycle completion pulse; resp_data  output  32  extended load result, 0 for stores.
REQ-008 SHALL have resp_err  output  1  qualified by resp_valid; misaligned request rejected.
REQ-009 SHALL have mem_req  output  1  word access request; mem_we  output  1  write.
REQ-010 SHALL have mem_addr  output  32  word address, bits [1:0] always 0; mem_be  output  4  byte enables.
REQ-011 SHALL have mem_wdata  output  32  lane-aligned store data; mem_rdata  input  32  read word; mem_ack  input  1  access done this cycle.

Function
REQ-012 SHALL implement FSM IDLE -> ACC0 -> (ACC1) -> RESP -> IDLE.
REQ-013 SHALL assert req_ready only in IDLE; one outstanding request max.
REQ-014 SHALL register req_fn/addr/wdata on acceptance; later pipeline input changes ignored.
REQ-015 SHALL hold mem_req, mem_addr, mem_be, mem_we, mem_wdata stable in ACCx until mem_ack (mem_ack may arrive same cycle as mem_req).
REQ-016 SHALL, for aligned access: accept cycle N, mem_req cycle N+1, resp_valid the cycle after mem_ack (minimum N+2).
REQ-017 SHALL classify as split: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[1:0]==3.
REQ-018 SHALL, for split access, perform word addr&~3 in ACC0 then (addr&~3)+4 in ACC1; 32-bit address wrap-around permitted.
REQ-019 SHALL form store lanes as 64-bit ({32'b0,wdata} << 8*addr[1:0]) with 8-byte mask likewise shifted; low half to ACC0, high half to ACC1.
REQ-020 SHALL form load result from {rdata_ACC1, rdata_ACC0} >> 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-021 SHALL capture mem_rdata only in the cycle mem_ack is high.
REQ-022 SHALL pulse resp_valid exactly one cycle in RESP; resp_data held until next resp_valid.
REQ-023 SHALL ignore mem_ack outside ACC0/ACC1.

Reset
REQ-024 SHALL on reset low force IDLE immediately; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0, resp_data=0, req_ready=0 while reset low, 1 after release.
REQ-025 SHALL discard an in-flight access on reset; a partially written split store is not rolled back.

Configuration
REQ-026 SHALL with LSU_MISALIGN_EN defined perform split accesses per REQ-017..020.
REQ-027 SHALL without LSU_MISALIGN_EN treat any misaligned request (halfword addr[0]=1, word addr[1:0]!=0) as error: no mem_req, resp_valid+resp_err the cycle after acceptance, resp_data=0.

Structure
REQ-028 SHALL take MEM_* codes from define.vh; FSM state encoding and LSU_* widths in a shared lsu_pkg.
REQ-029 SHALL place lane shift/extend logic in sub-module lsu_align (combinational, used for both store and load paths).

Verification
REQ-030 LW addr=0x100, mem_rdata=0x8899AABB, ack same cycle -> one mem_req (addr 0x100, be 1111), resp_data=0x8899AABB at accept+2.
REQ-031 LB addr=0x103, rdata=0x80000000 -> be 1000, resp_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SW addr=0x102, wdata=0x11223344 (MISALIGN_EN) -> ACC0 addr 0x100 be 1100 wdata 0x33440000; ACC1 addr 0x104 be 0011 wdata 0x00001122.
REQ-033 LH addr=0x103, words 0xAB000000/0x000000CD, ack delayed 3 cycles each (MISALIGN_EN) -> resp_data=0xFFFFCDAB, req_ready low throughout.
REQ-034 Without LSU_MISALIGN_EN, LW addr=0x101 -> no mem_req, resp_err=1 at accept+1.
REQ-035 Reset asserted while waiting for mem_ack in ACC1 -> mem_req low immediately, no resp_valid, req_ready=1 first cycle after release.
